// File: rtl/iob_csrs_master.sv
// iob_csrs_master: single-outstanding IOb bus master for a CSR bank; cmd_* request in, rsp_* response out, iob_* to subordinate, busy_o/err_cnt_o status
module iob_csrs_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_wstrb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_we_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic                iob_rready_o,
  output logic                busy_o,
  output logic [7:0]          err_cnt_o
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT_RD = 2'd2, RSP = 2'd3;
  localparam logic [TIMEOUT_W-1:0] T_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [1:0] state;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [TIMEOUT_W-1:0] timer;
  logic tmo;
  assign tmo = timer == T_LAST;
  assign cmd_ready_o = state == IDLE;
  assign iob_valid_o = state == REQ;
  assign iob_rready_o = state == WAIT_RD;
  assign rsp_valid_o = state == RSP;
  assign busy_o = state != IDLE;
  assign iob_addr_o = addr;
  assign iob_wdata_o = wdata;
  assign iob_wstrb_o = we ? wstrb : '0;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      we <= 1'b0;
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
      timer <= '0;
      rsp_we_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o <= 1'b0;
      err_cnt_o <= '0;
    end else if (cke_i) begin
      case (state)
        IDLE: if (cmd_valid_i) begin
          we <= cmd_we_i;
          addr <= cmd_addr_i;
          wdata <= cmd_wdata_i;
          wstrb <= cmd_wstrb_i;
          timer <= '0;
          state <= REQ;
        end
        REQ: if (iob_ready_i) begin
          timer <= '0;
          state <= we ? RSP : WAIT_RD;
          rsp_we_o <= we;
          rsp_rdata_o <= '0;
          rsp_err_o <= 1'b0;
        end else if (tmo) begin
          state <= RSP;
          rsp_we_o <= we;
          rsp_rdata_o <= '0;
          rsp_err_o <= 1'b1;
          err_cnt_o <= err_cnt_o + 8'(~&err_cnt_o);
        end else timer <= timer + 1'b1;
        WAIT_RD: if (iob_rvalid_i) begin
          state <= RSP;
          rsp_rdata_o <= iob_rdata_i;
          rsp_err_o <= 1'b0;
        end else if (tmo) begin
          state <= RSP;
          rsp_rdata_o <= '0;
          rsp_err_o <= 1'b1;
          err_cnt_o <= err_cnt_o + 8'(~&err_cnt_o);
        end else timer <= timer + 1'b1;
        default: if (rsp_ready_i) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_iob_csrs_master.sv
// tb_iob_csrs_master: directed self-checking bench for iob_csrs_master
`timescale 1ns/1ps
module tb_iob_csrs_master;
  logic clk = 1'b0, cke, rst;
  logic cmd_valid, cmd_ready, cmd_we;
  logic [4:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0] cmd_wstrb;
  logic rsp_valid, rsp_ready, rsp_we, rsp_err;
  logic [31:0] rsp_rdata;
  logic iob_valid, iob_ready, iob_rvalid, iob_rready, busy;
  logic [4:0] iob_addr;
  logic [31:0] iob_wdata, iob_rdata;
  logic [3:0] iob_wstrb;
  logic [7:0] err_cnt;
  int vectors = 0, miscompares = 0;
  iob_csrs_master dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_we_o(rsp_we),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .iob_valid_o(iob_valid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata),
    .iob_wstrb_o(iob_wstrb), .iob_ready_i(iob_ready), .iob_rvalid_i(iob_rvalid),
    .iob_rdata_i(iob_rdata), .iob_rready_o(iob_rready),
    .busy_o(busy), .err_cnt_o(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    step();
    cmd_valid = 1'b0;
  endtask
  task automatic drain();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    cke = 1'b1; rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0; iob_ready = 1'b0;
    iob_rvalid = 1'b0; iob_rdata = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_iob_valid", iob_valid, 0);
    chk("rst_iob_rready", iob_rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    // write, subordinate ready immediately
    iob_ready = 1'b1;
    send(1'b1, 5'h4, 32'hDEADBEEF, 4'hF);
    chk("wr_iob_valid", iob_valid, 1);
    chk("wr_iob_addr", iob_addr, 5'h4);
    chk("wr_iob_wdata", iob_wdata, 32'hDEADBEEF);
    chk("wr_iob_wstrb", iob_wstrb, 4'hF);
    chk("wr_cmd_ready", cmd_ready, 0);
    step();
    iob_ready = 1'b0;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_iob_valid_drop", iob_valid, 0);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_rsp_we", rsp_we, 1);
    drain();
    chk("wr_idle", busy, 0);
    // read, ready after 3 cycles, rvalid 2 cycles later; rvalid in accept cycle ignored
    send(1'b0, 5'h8, 32'h0, 4'hF);
    chk("rd_iob_wstrb", iob_wstrb, 0);
    chk("rd_iob_addr", iob_addr, 5'h8);
    step(); chk("rd_busy1", busy, 1);
    step(); chk("rd_iob_valid3", iob_valid, 1);
    iob_ready = 1'b1; iob_rvalid = 1'b1; iob_rdata = 32'h00000BAD;
    step();
    iob_ready = 1'b0; iob_rvalid = 1'b0;
    chk("rd_wait_rready", iob_rready, 1);
    chk("rd_wait_no_rsp", rsp_valid, 0);
    chk("rd_wait_busy", busy, 1);
    step();
    chk("rd_wait_busy2", busy, 1);
    iob_rvalid = 1'b1; iob_rdata = 32'h12345678;
    step();
    iob_rvalid = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("rd_rsp_err", rsp_err, 0);
    chk("rd_rsp_we", rsp_we, 0);
    // response back-pressure with a command pending
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 5'h10; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'h3;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, 32'h12345678);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("hold_idle_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("hold_next_addr", iob_addr, 5'h10);
    chk("hold_next_wdata", iob_wdata, 32'hCAFEF00D);
    chk("hold_next_wstrb", iob_wstrb, 4'h3);
    iob_ready = 1'b1;
    step();
    iob_ready = 1'b0;
    drain();
    // exit condition in the final timeout cycle wins
    send(1'b1, 5'h1, 32'h1, 4'h1);
    for (int i = 0; i < 254; i++) step();
    chk("race_still_valid", iob_valid, 1);
    iob_ready = 1'b1;
    step();
    iob_ready = 1'b0;
    chk("race_rsp_valid", rsp_valid, 1);
    chk("race_rsp_err", rsp_err, 0);
    chk("race_err_cnt", err_cnt, 0);
    drain();
    // 256 timeouts, counter saturates
    for (int k = 0; k < 256; k++) begin
      send(1'b0, 5'h2, 32'h0, 4'h0);
      n = 0;
      while (iob_valid && n < 400) begin n++; step(); end
      chk("tmo_cycles", n, 255);
      chk("tmo_err_cnt", err_cnt, (k < 255) ? k + 1 : 255);
      if (k == 0) begin
        chk("tmo_rsp_err", rsp_err, 1);
        chk("tmo_rsp_rdata", rsp_rdata, 0);
        chk("tmo_rsp_valid", rsp_valid, 1);
      end
      drain();
    end
    chk("tmo_sat", err_cnt, 255);
    // 10-cycle clock-enable stall in REQ delays the timeout by 10 cycles
    send(1'b0, 5'h3, 32'h0, 4'h0);
    n = 0;
    while (iob_valid && n < 400) begin
      cke = !(n >= 5 && n < 15);
      iob_ready = (n == 9);
      n++;
      step();
    end
    cke = 1'b1; iob_ready = 1'b0;
    chk("stall_cycles", n, 265);
    chk("stall_rsp_err", rsp_err, 1);
    chk("stall_err_cnt", err_cnt, 255);
    drain();
    // reset in WAIT_RD with clock enable low, then stray rvalid
    send(1'b0, 5'h5, 32'h0, 4'h0);
    iob_ready = 1'b1;
    step();
    iob_ready = 1'b0;
    chk("rstw_rready", iob_rready, 1);
    rst = 1'b1; cke = 1'b0;
    step();
    rst = 1'b0; cke = 1'b1;
    chk("rstw_busy", busy, 0);
    chk("rstw_err_cnt", err_cnt, 0);
    chk("rstw_cmd_ready", cmd_ready, 1);
    iob_rvalid = 1'b1; iob_rdata = 32'h5;
    step();
    iob_rvalid = 1'b0;
    chk("rstw_no_rsp", rsp_valid, 0);
    chk("rstw_rdata", rsp_rdata, 0);
    chk("rstw_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
